// File: rtl/sram_avalon_responder.sv
// Avalon-MM responder driving an asynchronous 16-bit SRAM.
// Every command becomes a registered, glitch-free read or write cycle.
module sram_avalon_responder #(
  parameter int unsigned READ_CYCLES  = 1,
  parameter int unsigned WRITE_CYCLES = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [19:0] address,
  input  logic [1:0]  byteenable,
  input  logic        read,
  input  logic        write,
  input  logic [15:0] writedata,
  output logic [15:0] readdata,
  output logic        readdatavalid,
  output logic        waitrequest,
  inout  wire  [15:0] SRAM_DQ,
  output logic [19:0] SRAM_ADDR,
  output logic        SRAM_LB_N,
  output logic        SRAM_UB_N,
  output logic        SRAM_CE_N,
  output logic        SRAM_OE_N,
  output logic        SRAM_WE_N
);

  localparam int unsigned MAX_CYC = (READ_CYCLES > WRITE_CYCLES) ? READ_CYCLES : WRITE_CYCLES;
  localparam int unsigned CW      = $clog2(MAX_CYC + 1);

  typedef enum logic [1:0] {IDLE, RD, WR, WR_HOLD} state_t;

  state_t        state, state_d;
  logic [CW-1:0] cnt, cnt_d;
  logic [19:0]   addr_d;
  logic [1:0]    be_q, be_d;
  logic [15:0]   wdata_q, wdata_d;
  logic          rd_cap;
  logic          ce_d, oe_d, we_d, lb_d, ub_d;
  logic          dq_oe, dq_oe_d;

  assign waitrequest = reset | (state != IDLE);
  assign SRAM_DQ     = dq_oe ? wdata_q : 'z;

  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    addr_d  = SRAM_ADDR;
    be_d    = be_q;
    wdata_d = wdata_q;
    rd_cap  = 1'b0;
    case (state)
      IDLE: begin
        if (read | write) begin
          addr_d  = address;
          be_d    = byteenable;
          wdata_d = writedata;
          cnt_d   = '0;
          state_d = read ? RD : WR;
        end
      end
      RD: begin
        if (cnt == CW'(READ_CYCLES - 1)) begin
          rd_cap  = 1'b1;
          state_d = IDLE;
        end else begin
          cnt_d = cnt + 1'b1;
        end
      end
      WR: begin
        if (cnt == CW'(WRITE_CYCLES - 1)) state_d = WR_HOLD;
        else                              cnt_d   = cnt + 1'b1;
      end
      WR_HOLD: state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Pin levels are decoded from the state being entered so they leave flops.
    ce_d    = 1'b1;
    oe_d    = 1'b1;
    we_d    = 1'b1;
    lb_d    = 1'b1;
    ub_d    = 1'b1;
    dq_oe_d = 1'b0;
    case (state_d)
      RD: begin
        ce_d = 1'b0;
        oe_d = 1'b0;
        lb_d = ~be_d[0];
        ub_d = ~be_d[1];
      end
      WR: begin
        ce_d    = 1'b0;
        we_d    = 1'b0;
        lb_d    = ~be_d[0];
        ub_d    = ~be_d[1];
        dq_oe_d = 1'b1;
      end
      WR_HOLD: begin
        ce_d    = 1'b0;
        lb_d    = ~be_d[0];
        ub_d    = ~be_d[1];
        dq_oe_d = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      cnt           <= '0;
      SRAM_ADDR     <= '0;
      be_q          <= '0;
      wdata_q       <= '0;
      readdata      <= '0;
      readdatavalid <= 1'b0;
      SRAM_CE_N     <= 1'b1;
      SRAM_OE_N     <= 1'b1;
      SRAM_WE_N     <= 1'b1;
      SRAM_LB_N     <= 1'b1;
      SRAM_UB_N     <= 1'b1;
      dq_oe         <= 1'b0;
    end else begin
      state         <= state_d;
      cnt           <= cnt_d;
      SRAM_ADDR     <= addr_d;
      be_q          <= be_d;
      wdata_q       <= wdata_d;
      readdatavalid <= rd_cap;
      if (rd_cap) readdata <= SRAM_DQ & {{8{be_q[1]}}, {8{be_q[0]}}};
      SRAM_CE_N     <= ce_d;
      SRAM_OE_N     <= oe_d;
      SRAM_WE_N     <= we_d;
      SRAM_LB_N     <= lb_d;
      SRAM_UB_N     <= ub_d;
      dq_oe         <= dq_oe_d;
    end
  end

endmodule

// File: tb/tb_sram_avalon_responder.sv
// Bench for sram_avalon_responder: two instances (default and 3/2 cycles),
// each backed by a 4K-word mirrored SRAM model, checked against a reference memory.
module tb_sram_avalon_responder;

  localparam int unsigned RC_B = 3;
  localparam int unsigned WC_B = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [19:0] address;
  logic [1:0]  byteenable;
  logic [15:0] writedata;
  logic        rd_a, wr_a, rd_b, wr_b;

  logic [15:0] rdata_a, rdata_b;
  logic        rdv_a, rdv_b, wait_a, wait_b;
  wire  [15:0] dq_a, dq_b;
  logic [19:0] sa_a, sa_b;
  logic        lb_a, ub_a, ce_a, oe_a, we_a;
  logic        lb_b, ub_b, ce_b, oe_b, we_b;

  always #10 clk = ~clk;

  sram_avalon_responder dut_a (
    .clk(clk), .reset(reset), .address(address), .byteenable(byteenable),
    .read(rd_a), .write(wr_a), .writedata(writedata),
    .readdata(rdata_a), .readdatavalid(rdv_a), .waitrequest(wait_a),
    .SRAM_DQ(dq_a), .SRAM_ADDR(sa_a), .SRAM_LB_N(lb_a), .SRAM_UB_N(ub_a),
    .SRAM_CE_N(ce_a), .SRAM_OE_N(oe_a), .SRAM_WE_N(we_a)
  );

  sram_avalon_responder #(.READ_CYCLES(RC_B), .WRITE_CYCLES(WC_B)) dut_b (
    .clk(clk), .reset(reset), .address(address), .byteenable(byteenable),
    .read(rd_b), .write(wr_b), .writedata(writedata),
    .readdata(rdata_b), .readdatavalid(rdv_b), .waitrequest(wait_b),
    .SRAM_DQ(dq_b), .SRAM_ADDR(sa_b), .SRAM_LB_N(lb_b), .SRAM_UB_N(ub_b),
    .SRAM_CE_N(ce_b), .SRAM_OE_N(oe_b), .SRAM_WE_N(we_b)
  );

  // Asynchronous SRAM models: power up with contents = address, write while WE_N is low.
  logic [15:0] smem_a [4096];
  logic [15:0] smem_b [4096];
  logic        init_a = 1'b0;
  logic        init_b = 1'b0;

  assign dq_a = (!ce_a && !oe_a) ? smem_a[sa_a[11:0]] : 16'bz;
  assign dq_b = (!ce_b && !oe_b) ? smem_b[sa_b[11:0]] : 16'bz;

  always @(negedge clk) begin
    if (!init_a) begin
      for (int i = 0; i < 4096; i++) smem_a[i] <= 16'(i);
      init_a <= 1'b1;
    end else if (!ce_a && !we_a) begin
      if (!lb_a) smem_a[sa_a[11:0]][7:0]  <= dq_a[7:0];
      if (!ub_a) smem_a[sa_a[11:0]][15:8] <= dq_a[15:8];
    end
  end

  always @(negedge clk) begin
    if (!init_b) begin
      for (int i = 0; i < 4096; i++) smem_b[i] <= 16'(i);
      init_b <= 1'b1;
    end else if (!ce_b && !we_b) begin
      if (!lb_b) smem_b[sa_b[11:0]][7:0]  <= dq_b[7:0];
      if (!ub_b) smem_b[sa_b[11:0]][15:8] <= dq_b[15:8];
    end
  end

  // Observation mux for the instance under test.
  logic        sel;
  logic [15:0] o_rdata, o_dq;
  logic        o_rdv, o_wait, o_lb_n, o_ub_n, o_ce_n, o_oe_n, o_we_n;
  logic [19:0] o_addr;

  always_comb begin
    o_rdata = sel ? rdata_b : rdata_a;
    o_dq    = sel ? dq_b    : dq_a;
    o_rdv   = sel ? rdv_b   : rdv_a;
    o_wait  = sel ? wait_b  : wait_a;
    o_addr  = sel ? sa_b    : sa_a;
    o_lb_n  = sel ? lb_b    : lb_a;
    o_ub_n  = sel ? ub_b    : ub_a;
    o_ce_n  = sel ? ce_b    : ce_a;
    o_oe_n  = sel ? oe_b    : oe_a;
    o_we_n  = sel ? we_b    : we_a;
  end

  // Reference memory: what each SRAM should hold after the accepted commands.
  logic [15:0] rmem [2][4096];

  int unsigned total = 0;
  int unsigned bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h (inst=%0d t=%0t)", tag, got, exp, sel, $time);
    end
  endtask

  function automatic logic [15:0] sm(input logic s, input logic [11:0] i);
    return s ? smem_b[i] : smem_a[i];
  endfunction

  task automatic drive(input logic s, input logic rd, input logic wr);
    rd_a = !s && rd;
    wr_a = !s && wr;
    rd_b = s && rd;
    wr_b = s && wr;
  endtask

  // One command on instance s, then eight observed cycles checked against cycle-count rules.
  task automatic do_cmd(input logic s, input logic rd, input logic wr, input logic [19:0] a,
                        input logic [1:0] be, input logic [15:0] wd, output logic [15:0] rdo);
    int unsigned rc, wc, n_oe, n_we, n_ce, n_rdv, rdv_cyc, idle_cyc;
    logic        acc;
    logic [15:0] exp_rd, mask;
    logic [1:0]  nbe;
    rc = s ? RC_B : 1;
    wc = s ? WC_B : 1;
    n_oe = 0; n_we = 0; n_ce = 0; n_rdv = 0; rdv_cyc = 0; idle_cyc = 0;
    mask   = {{8{be[1]}}, {8{be[0]}}};
    nbe    = ~be;
    exp_rd = rmem[s][a[11:0]] & mask;
    rdo    = '0;
    acc    = 1'b0;
    sel    = s;
    @(posedge clk); #1;
    address = a; byteenable = be; writedata = wd;
    drive(s, rd, wr);
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (!o_wait) begin
        acc = 1'b1;
        break;
      end
    end
    @(posedge clk); #1;
    drive(s, 1'b0, 1'b0);
    if (!acc) begin
      check("accept_timeout", 32'd1, 32'd0);
      return;
    end
    for (int unsigned c = 1; c <= 8; c++) begin
      @(negedge clk);
      if (!o_oe_n) n_oe++;
      if (!o_we_n) n_we++;
      if (!o_ce_n) n_ce++;
      if (o_rdv) begin
        n_rdv++;
        rdv_cyc = c;
        rdo     = o_rdata;
      end
      if (idle_cyc == 0 && !o_wait) idle_cyc = c;
      check("oe_we_overlap", 32'(!o_oe_n && !o_we_n), 32'd0);
      if (!o_ce_n) begin
        check("sram_addr", 32'(o_addr), 32'(a));
        check("lb_ub", 32'({o_ub_n, o_lb_n}), 32'({nbe[1], nbe[0]}));
        if (!rd) check("dq_write", 32'(o_dq), 32'(wd));
      end else begin
        check("idle_pins", 32'({o_oe_n, o_we_n, o_lb_n, o_ub_n}), 32'hf);
      end
    end
    check("oe_cycles",   n_oe,     rd ? rc : 0);
    check("we_cycles",   n_we,     rd ? 0 : wc);
    check("ce_cycles",   n_ce,     rd ? rc : wc + 1);
    check("rdv_count",   n_rdv,    rd ? 1 : 0);
    check("rdv_cycle",   rdv_cyc,  rd ? rc + 1 : 0);
    check("idle_cycle",  idle_cyc, rd ? rc + 1 : wc + 2);
    check("addr_hold",   32'(o_addr), 32'(a));
    if (rd) check("readdata", 32'(rdo), 32'(exp_rd));
    else begin
      if (be[0]) rmem[s][a[11:0]][7:0]  = wd[7:0];
      if (be[1]) rmem[s][a[11:0]][15:8] = wd[15:8];
    end
    check("mem", 32'(sm(s, a[11:0])), 32'(rmem[s][a[11:0]]));
  endtask

  initial begin
    logic [15:0] r;
    logic        acc;
    int unsigned op;
    for (int s = 0; s < 2; s++)
      for (int i = 0; i < 4096; i++) rmem[s][i] = 16'(i);
    sel = 1'b0;
    address = '0; byteenable = '0; writedata = '0;
    drive(1'b0, 1'b0, 1'b0);

    // Reset values on both instances.
    repeat (3) @(posedge clk);
    #1;
    for (int s = 0; s < 2; s++) begin
      sel = s[0];
      #1;
      check("rst_readdata", 32'(o_rdata), 32'd0);
      check("rst_rdv",      32'(o_rdv), 32'd0);
      check("rst_addr",     32'(o_addr), 32'd0);
      check("rst_pins",     32'({o_ce_n, o_oe_n, o_we_n, o_lb_n, o_ub_n}), 32'h1f);
      check("rst_wait",     32'(o_wait), 32'd1);
    end
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("wait_after_rst", 32'(o_wait), 32'd0);

    // Back-to-back reads with read held high, incrementing address.
    sel = 1'b0;
    @(posedge clk); #1;
    address = '0; byteenable = 2'b11;
    drive(1'b0, 1'b1, 1'b0);
    for (int unsigned cyc = 0; cyc < 16; cyc++) begin
      @(negedge clk);
      acc = !o_wait;
      check("burst_wait", 32'(o_wait), 32'(cyc[0]));
      check("burst_rdv",  32'(o_rdv), 32'(cyc >= 2 && !cyc[0]));
      if (cyc >= 2 && !cyc[0])
        check("burst_data", 32'(o_rdata), 32'(rmem[0][cyc / 2 - 1]));
      @(posedge clk); #1;
      if (acc) address = address + 20'd1;
    end
    drive(1'b0, 1'b0, 1'b0);
    repeat (3) @(posedge clk);

    // Reset during the RD cycle of a read.
    @(posedge clk); #1;
    address = 20'h00042; byteenable = 2'b11;
    drive(1'b0, 1'b1, 1'b0);
    @(negedge clk);
    check("mr_accept", 32'(o_wait), 32'd0);
    @(posedge clk); #1;
    drive(1'b0, 1'b0, 1'b0);
    #3;
    check("mr_in_rd", 32'(o_oe_n), 32'd0);
    reset = 1'b1;
    #1;
    check("mr_pins",     32'({o_ce_n, o_oe_n, o_we_n, o_lb_n, o_ub_n}), 32'h1f);
    check("mr_wait",     32'(o_wait), 32'd1);
    check("mr_rdv",      32'(o_rdv), 32'd0);
    check("mr_readdata", 32'(o_rdata), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("mr_wait_after", 32'(o_wait), 32'd0);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("mr_no_rdv", 32'(o_rdv), 32'd0);
    end

    // Directed write/read sequences.
    do_cmd(1'b0, 1'b0, 1'b1, 20'h00123, 2'b11, 16'hBEEF, r);
    do_cmd(1'b0, 1'b1, 1'b0, 20'h00123, 2'b11, 16'h0000, r);
    check("beef_read", 32'(r), 32'hBEEF);
    do_cmd(1'b0, 1'b0, 1'b1, 20'h00123, 2'b01, 16'h1234, r);
    check("be01_mem", 32'(sm(1'b0, 12'h123)), 32'hBE34);
    do_cmd(1'b0, 1'b1, 1'b0, 20'h00123, 2'b10, 16'h0000, r);
    check("be10_read", 32'(r), 32'hBE00);
    do_cmd(1'b0, 1'b1, 1'b1, 20'h00010, 2'b11, 16'hDEAD, r);
    check("rw_read", 32'(r), 32'h0010);
    check("rw_mem",  32'(sm(1'b0, 12'h010)), 32'h0010);
    do_cmd(1'b0, 1'b1, 1'b0, 20'h00123, 2'b00, 16'h0000, r);
    check("be00_read", 32'(r), 32'h0000);
    do_cmd(1'b1, 1'b0, 1'b1, 20'hABCDE, 2'b11, 16'h5A5A, r);
    do_cmd(1'b1, 1'b1, 1'b0, 20'hABCDE, 2'b11, 16'h0000, r);
    check("slow_read", 32'(r), 32'h5A5A);

    // Randomized traffic on both instances against the reference memory.
    for (int s = 0; s < 2; s++) begin
      for (int n = 0; n < 25; n++) begin
        op = $urandom_range(0, 5);
        do_cmd(s[0], op != 2 && op != 3, op >= 2 && op != 5 ? 1'b1 : 1'b0,
               {8'($urandom), 12'($urandom_range(0, 7))}, 2'($urandom), 16'($urandom), r);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

endmodule
